// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//   Central stall/flush sequencer for the 5-stage pipeline. Handles the hazards
//   that EX-stage forwarding cannot resolve: load-use, taken-branch redirect,
//   instruction/data memory wait, and the HLT drain sequence. Keeps a
//   saturating count of stalled cycles for performance debug.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   ifid_rs/rt            source registers of the instruction in ID
//   ifid_uses_rs/rt       ID instruction actually reads rs / rt
//   idex_mem_read         EX instruction is a load
//   idex_reg_write        EX instruction writes a register
//   idex_wr               EX destination register
//   ex_branch_taken       branch resolved taken in EX
//   imem_busy, dmem_busy  instruction / data memory not ready
//   halt_id               HLT decoded in ID
//   pc_write..memwb_write pipeline register enables (combinational)
//   ifid_flush/idex_flush bubble insertion (combinational)
//   halted                pipeline empty after HLT (registered)
//   stall_count           saturating count of RUN cycles with pc_write=0
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_W   = 4,
  parameter int DRAIN_CYCLES = 4,
  parameter int CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] ifid_rs,
  input  logic [REG_ADDR_W-1:0] ifid_rt,
  input  logic                  ifid_uses_rs,
  input  logic                  ifid_uses_rt,
  input  logic                  idex_mem_read,
  input  logic                  idex_reg_write,
  input  logic [REG_ADDR_W-1:0] idex_wr,
  input  logic                  ex_branch_taken,
  input  logic                  imem_busy,
  input  logic                  dmem_busy,
  input  logic                  halt_id,
  output logic                  pc_write,
  output logic                  ifid_write,
  output logic                  ifid_flush,
  output logic                  idex_write,
  output logic                  idex_flush,
  output logic                  exmem_write,
  output logic                  memwb_write,
  output logic                  halted,
  output logic [CNT_W-1:0]      stall_count
);

  localparam int DRN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DRN_W-1:0] DRN_LOAD = DRN_W'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t            state_r;
  logic [DRN_W-1:0]  drain_cnt_r;
  logic [CNT_W-1:0]  stall_count_r;
  logic              halted_r;

  logic              lu_s;
  logic              pc_write_s;
  logic              ifid_write_s;
  logic              ifid_flush_s;
  logic              idex_write_s;
  logic              idex_flush_s;
  logic              exmem_write_s;
  logic              memwb_write_s;

  // Load-use detection: a load in EX whose non-R0 destination is read in ID.
  always_comb begin
    lu_s = idex_mem_read & idex_reg_write &
           (idex_wr != {REG_ADDR_W{1'b0}}) &
           ((ifid_uses_rs & (ifid_rs == idex_wr)) |
            (ifid_uses_rt & (ifid_rt == idex_wr)));
  end

  // Pipeline-register controls decoded from state and current hazards.
  always_comb begin
    pc_write_s    = 1'b0;
    ifid_write_s  = 1'b0;
    ifid_flush_s  = 1'b0;
    idex_write_s  = 1'b0;
    idex_flush_s  = 1'b0;
    exmem_write_s = 1'b0;
    memwb_write_s = 1'b0;
    if (!rst_n) begin
      // Everything held while reset is asserted.
      pc_write_s = 1'b0;
    end else begin
      case (state_r)
        RUN: begin
          if (dmem_busy) begin
            // Full freeze; a pending branch stays asserted until unfrozen.
            pc_write_s = 1'b0;
          end else if (ex_branch_taken) begin
            // Redirect: wrong-path instructions in IF/ID and ID/EX are killed,
            // which also drops any load-use or HLT seen on the wrong path.
            pc_write_s    = 1'b1;
            ifid_write_s  = 1'b1;
            ifid_flush_s  = 1'b1;
            idex_write_s  = 1'b1;
            idex_flush_s  = 1'b1;
            exmem_write_s = 1'b1;
            memwb_write_s = 1'b1;
          end else if (lu_s) begin
            // Hold PC and IF/ID, push a bubble into EX.
            idex_write_s  = 1'b1;
            idex_flush_s  = 1'b1;
            exmem_write_s = 1'b1;
            memwb_write_s = 1'b1;
          end else if (imem_busy || halt_id) begin
            // Stop fetching and feed a bubble into ID; older work proceeds.
            ifid_write_s  = 1'b1;
            ifid_flush_s  = 1'b1;
            idex_write_s  = 1'b1;
            exmem_write_s = 1'b1;
            memwb_write_s = 1'b1;
          end else begin
            pc_write_s    = 1'b1;
            ifid_write_s  = 1'b1;
            idex_write_s  = 1'b1;
            exmem_write_s = 1'b1;
            memwb_write_s = 1'b1;
          end
        end
        DRAIN: begin
          ifid_flush_s = 1'b1;
          if (dmem_busy) begin
            idex_write_s = 1'b0;
          end else begin
            idex_write_s  = 1'b1;
            exmem_write_s = 1'b1;
            memwb_write_s = 1'b1;
          end
        end
        HALTED: begin
          pc_write_s = 1'b0;
        end
        default: begin
          pc_write_s = 1'b0;
        end
      endcase
    end
  end

  // Sequencer state, drain counter, halted flag and stall counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= RUN;
      drain_cnt_r   <= {DRN_W{1'b0}};
      stall_count_r <= {CNT_W{1'b0}};
      halted_r      <= 1'b0;
    end else begin
      case (state_r)
        RUN: begin
          if (!pc_write_s && (stall_count_r != {CNT_W{1'b1}})) begin
            stall_count_r <= stall_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end else begin
            stall_count_r <= stall_count_r;
          end
          if (!dmem_busy && !ex_branch_taken && !lu_s && !imem_busy && halt_id) begin
            state_r     <= DRAIN;
            drain_cnt_r <= DRN_LOAD;
          end else begin
            state_r     <= RUN;
            drain_cnt_r <= drain_cnt_r;
          end
          halted_r <= 1'b0;
        end
        DRAIN: begin
          if (dmem_busy) begin
            state_r     <= DRAIN;
            drain_cnt_r <= drain_cnt_r;
            halted_r    <= 1'b0;
          end else if (drain_cnt_r == {DRN_W{1'b0}}) begin
            state_r     <= HALTED;
            drain_cnt_r <= drain_cnt_r;
            halted_r    <= 1'b1;
          end else begin
            state_r     <= DRAIN;
            drain_cnt_r <= drain_cnt_r - {{(DRN_W-1){1'b0}}, 1'b1};
            halted_r    <= 1'b0;
          end
        end
        HALTED: begin
          state_r  <= HALTED;
          halted_r <= 1'b1;
        end
        default: begin
          state_r     <= RUN;
          drain_cnt_r <= {DRN_W{1'b0}};
          halted_r    <= 1'b0;
        end
      endcase
    end
  end

  assign pc_write    = pc_write_s;
  assign ifid_write  = ifid_write_s;
  assign ifid_flush  = ifid_flush_s;
  assign idex_write  = idex_write_s;
  assign idex_flush  = idex_flush_s;
  assign exmem_write = exmem_write_s;
  assign memwb_write = memwb_write_s;
  assign halted      = halted_r;
  assign stall_count = stall_count_r;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
//   Directed-vector bench with a scoreboard. The stimulus process drives the
//   inputs just after each rising edge and queues the expected controls,
//   halted flag and stall counter; a monitor compares them on the falling edge.
//   Control vector order: {pc, ifid_w, ifid_f, idex_w, idex_f, exmem_w, memwb_w}.
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

  localparam logic [6:0] V_ZERO = 7'b0000000;
  localparam logic [6:0] V_NORM = 7'b1101011;
  localparam logic [6:0] V_BR   = 7'b1111111;
  localparam logic [6:0] V_LU   = 7'b0001111;
  localparam logic [6:0] V_WAIT = 7'b0111011;
  localparam logic [6:0] V_DRN  = 7'b0011011;
  localparam logic [6:0] V_DRNF = 7'b0010000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] ifid_rs, ifid_rt, idex_wr;
  logic       ifid_uses_rs, ifid_uses_rt, idex_mem_read, idex_reg_write;
  logic       ex_branch_taken, imem_busy, dmem_busy, halt_id;
  logic       pc_write, ifid_write, ifid_flush, idex_write, idex_flush;
  logic       exmem_write, memwb_write, halted;
  logic [3:0] stall_count;

  logic [6:0] exp_ctl_q[$];
  logic       exp_h_q[$];
  logic [3:0] exp_cnt_q[$];
  string      exp_nm_q[$];

  int vectors = 0;
  int miscompares = 0;

  pipeline_hazard_ctrl #(.REG_ADDR_W(4), .DRAIN_CYCLES(4), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .ifid_uses_rs(ifid_uses_rs), .ifid_uses_rt(ifid_uses_rt),
    .idex_mem_read(idex_mem_read), .idex_reg_write(idex_reg_write),
    .idex_wr(idex_wr), .ex_branch_taken(ex_branch_taken),
    .imem_busy(imem_busy), .dmem_busy(dmem_busy), .halt_id(halt_id),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_write(idex_write), .idex_flush(idex_flush),
    .exmem_write(exmem_write), .memwb_write(memwb_write),
    .halted(halted), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  // Monitor: compare whatever the stimulus queued for this cycle.
  always @(negedge clk) begin
    if (exp_ctl_q.size() != 0) begin
      logic [6:0] ec;
      logic       eh;
      logic [3:0] en;
      string      nm;
      logic [6:0] act;
      ec = exp_ctl_q.pop_front();
      eh = exp_h_q.pop_front();
      en = exp_cnt_q.pop_front();
      nm = exp_nm_q.pop_front();
      act = {pc_write, ifid_write, ifid_flush, idex_write, idex_flush,
             exmem_write, memwb_write};
      vectors++;
      if (act !== ec) begin
        miscompares++;
        $display("FAIL %s ctl: got %b expected %b", nm, act, ec);
      end
      if (halted !== eh) begin
        miscompares++;
        $display("FAIL %s halted: got %b expected %b", nm, halted, eh);
      end
      if (stall_count !== en) begin
        miscompares++;
        $display("FAIL %s stall_count: got %0d expected %0d", nm, stall_count, en);
      end
    end
  end

  task automatic idle();
    ifid_rs = 4'd0; ifid_rt = 4'd0; idex_wr = 4'd0;
    ifid_uses_rs = 1'b0; ifid_uses_rt = 1'b0;
    idex_mem_read = 1'b0; idex_reg_write = 1'b0;
    ex_branch_taken = 1'b0; imem_busy = 1'b0; dmem_busy = 1'b0; halt_id = 1'b0;
  endtask

  // Queue expectations for the current cycle, then advance to just after the next edge.
  task automatic cyc(input logic [6:0] ec, input logic eh, input logic [3:0] en,
                     input string nm);
    exp_ctl_q.push_back(ec);
    exp_h_q.push_back(eh);
    exp_cnt_q.push_back(en);
    exp_nm_q.push_back(nm);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    cyc(V_ZERO, 1'b0, 4'd0, "reset");
    rst_n = 1'b1;
  endtask

  task automatic set_load(input logic [3:0] wr);
    idex_mem_read = 1'b1; idex_reg_write = 1'b1; idex_wr = wr;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    @(posedge clk); #1;
    do_reset();
    cyc(V_NORM, 1'b0, 4'd0, "idle");

    // Load-use on rt: one stall, bubble clears it.
    set_load(4'd3); ifid_rt = 4'd3; ifid_uses_rt = 1'b1;
    cyc(V_LU, 1'b0, 4'd0, "lu_rt");
    idle();
    cyc(V_NORM, 1'b0, 4'd1, "lu_after");
    // Load to R0 is never a hazard.
    set_load(4'd0); ifid_rt = 4'd0; ifid_uses_rt = 1'b1;
    cyc(V_NORM, 1'b0, 4'd1, "lu_r0");
    // rs match ignored unless rs is used.
    idle(); set_load(4'd5); ifid_rs = 4'd5;
    cyc(V_NORM, 1'b0, 4'd1, "lu_rs_unused");
    ifid_uses_rs = 1'b1;
    cyc(V_LU, 1'b0, 4'd1, "lu_rs");
    idle();
    cyc(V_NORM, 1'b0, 4'd2, "lu_rs_after");

    // Branch held during a 2-cycle data-memory freeze.
    ex_branch_taken = 1'b1; dmem_busy = 1'b1;
    cyc(V_ZERO, 1'b0, 4'd2, "br_freeze1");
    cyc(V_ZERO, 1'b0, 4'd3, "br_freeze2");
    dmem_busy = 1'b0;
    cyc(V_BR, 1'b0, 4'd4, "br_service");
    idle();
    cyc(V_NORM, 1'b0, 4'd4, "br_after");

    // Branch beats load-use.
    ex_branch_taken = 1'b1; set_load(4'd7); ifid_rs = 4'd7; ifid_uses_rs = 1'b1;
    cyc(V_BR, 1'b0, 4'd4, "br_vs_lu");
    idle();
    // Instruction memory wait.
    imem_busy = 1'b1;
    cyc(V_WAIT, 1'b0, 4'd4, "imem_wait");
    idle();
    // Branch beats HLT: no drain.
    ex_branch_taken = 1'b1; halt_id = 1'b1;
    cyc(V_BR, 1'b0, 4'd5, "br_vs_halt");
    idle();
    cyc(V_NORM, 1'b0, 4'd5, "no_drain");

    // Halt drain with a freeze on the 2nd DRAIN cycle.
    do_reset();
    halt_id = 1'b1;
    cyc(V_WAIT, 1'b0, 4'd0, "halt");
    ex_branch_taken = 1'b1; imem_busy = 1'b1;  // ignored in DRAIN
    cyc(V_DRN, 1'b0, 4'd1, "drain1");
    dmem_busy = 1'b1;
    cyc(V_DRNF, 1'b0, 4'd1, "drain2_frz");
    dmem_busy = 1'b0;
    cyc(V_DRN, 1'b0, 4'd1, "drain3");
    cyc(V_DRN, 1'b0, 4'd1, "drain4");
    cyc(V_DRN, 1'b0, 4'd1, "drain5");
    cyc(V_ZERO, 1'b1, 4'd1, "halted1");
    idle();
    cyc(V_ZERO, 1'b1, 4'd1, "halted2");

    // Asynchronous reset between edges in the middle of DRAIN.
    do_reset();
    halt_id = 1'b1;
    cyc(V_WAIT, 1'b0, 4'd0, "halt_b");
    idle();
    cyc(V_DRN, 1'b0, 4'd1, "drain_b1");
    #1;
    rst_n = 1'b0; ex_branch_taken = 1'b1;
    cyc(V_ZERO, 1'b0, 4'd0, "async_rst");
    rst_n = 1'b1; idle();
    cyc(V_NORM, 1'b0, 4'd0, "run_after_rst");

    // Saturation of the 4-bit counter.
    imem_busy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc(V_WAIT, 1'b0, (i > 15) ? 4'd15 : 4'(i), "sat");
    end
    idle();
    cyc(V_NORM, 1'b0, 4'd15, "sat_hold");

    // Let the monitor drain the queue, bounded.
    for (int i = 0; i < 10 && exp_ctl_q.size() != 0; i++) @(posedge clk);
    if (exp_ctl_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain_queue: got %0d pending expected 0", exp_ctl_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
